ps_fetch_queue: RTL

//  Instruction fetch queue between program memory and the program sequencer decode stage.
//  - Accepts fetch requests (address + chip-select) issued by the sequencer.
//  - Tracks in-flight PM reads and captures returned opcodes with their addresses in a FIFO.
//  - Presents the head opcode to decode; holds it under stall; discards all on jump/return flush.

---
 rtl/ps_fetch_queue.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ps_fetch_queue.sv
// Instruction fetch queue between program memory and the sequencer decode stage.
// Define IFQ_BYPASS_EN to forward a PM return straight to decode when the queue is empty.
module ps_fetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 32,
  parameter int unsigned PM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps_pm_cslt,
  input  logic [AW-1:0]            ps_pm_add,
  input  logic                     ps_ifq_flush,
  input  logic                     stallb,
  input  logic [DW-1:0]            pm_ifq_op,
  output logic                     ifq_pm_cslt,
  output logic [AW-1:0]            ifq_pm_add,
  output logic                     ifq_ps_rdy,
  output logic [DW-1:0]            ifq_ps_op,
  output logic [AW-1:0]            ifq_ps_add,
  output logic                     ifq_ps_vld,
  output logic [$clog2(DEPTH):0]   ifq_ps_lvl
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = $clog2(DEPTH + PM_LAT + 1) + 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [PM_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [AW-1:0]     pipe_add_q [PM_LAT];
  logic [AW-1:0]     pipe_add_d [PM_LAT];
  logic [DW-1:0]     mem_op_q   [DEPTH];
  logic [AW-1:0]     mem_add_q  [DEPTH];

  logic [CW-1:0] cred;
  logic          accept;
  logic          pop;
  logic          fifo_vld;
  logic          fifo_pop;
  logic          push;
  logic          wr_en;
  logic          tail_vld;
  logic [AW-1:0] tail_add;
  logic          bypass;

  assign tail_vld = pipe_vld_q[PM_LAT-1];
  assign tail_add = pipe_add_q[PM_LAT-1];
  assign fifo_vld = (cnt_q != '0);

`ifdef IFQ_BYPASS_EN
  // Returns belonging to a stream being flushed must never reach decode.
  assign bypass = !fifo_vld && tail_vld && !ps_ifq_flush;
`else
  assign bypass = 1'b0;
`endif

  // Credit covers both stored entries and reads still in flight in PM.
  always_comb begin
    cred = CW'(cnt_q);
    for (int i = 0; i < PM_LAT; i++) begin
      cred = cred + CW'(pipe_vld_q[i]);
    end
  end

  always_comb begin
    ifq_ps_vld = fifo_vld;
    ifq_ps_op  = '0;
    ifq_ps_add = '0;
    if (fifo_vld) begin
      ifq_ps_op  = mem_op_q[rd_ptr_q];
      ifq_ps_add = mem_add_q[rd_ptr_q];
    end else if (bypass) begin
      ifq_ps_vld = 1'b1;
      ifq_ps_op  = pm_ifq_op;
      ifq_ps_add = tail_add;
    end
  end

  assign pop         = ifq_ps_vld & stallb;
  assign fifo_pop    = fifo_vld & stallb;
  // A bypassed return consumed by decode is not stored.
  assign push        = tail_vld & ~(bypass & stallb);
  assign wr_en       = push & ~ps_ifq_flush;
  assign ifq_ps_rdy  = (cred < CW'(DEPTH)) | pop;
  assign accept      = ps_pm_cslt & ifq_ps_rdy;
  assign ifq_pm_cslt = accept;
  assign ifq_pm_add  = ps_pm_add;
  assign ifq_ps_lvl  = cnt_q;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q;
    pipe_vld_d    = '0;
    pipe_vld_d[0] = accept;
    pipe_add_d[0] = ps_pm_add;
    // The request accepted in a flush cycle belongs to the new stream, so only older stages drop.
    for (int i = 1; i < PM_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1] & ~ps_ifq_flush;
      pipe_add_d[i] = pipe_add_q[i-1];
    end
    if (ps_ifq_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (fifo_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, fifo_pop})
        2'b10:   cnt_d = cnt_q + LW'(1);
        2'b01:   cnt_d = cnt_q - LW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < PM_LAT; i++) begin
        pipe_add_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < PM_LAT; i++) begin
        pipe_add_q[i] <= pipe_add_d[i];
      end
    end
  end

  // Storage needs no reset: occupancy alone qualifies every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_op_q[wr_ptr_q]  <= pm_ifq_op;
      mem_add_q[wr_ptr_q] <= tail_add;
    end
  end

  // Credit accounting must make a push into a full queue without a pop unreachable.
  assert property (@(posedge clk) disable iff (!rst)
    !(wr_en && !fifo_pop && (cnt_q == LW'(DEPTH))));

endmodule
